// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Two-port round-robin arbiter/sequencer in front of a single-port memory.
//   Port 0 (instruction fetch) and port 1 (data load/store) issue req/ack
//   transactions. One transaction runs at a time; read data is returned on
//   the port's rdata and completion is signalled by a one-cycle ack pulse.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   req0/1, we0/1         request (held until ack) and write enable per port
//   addr0/1, wdata0/1     address and write data per port
//   ack0/1, rdata0/1      completion pulse and read result per port
//   grant                 port owning the current/last transaction
//   busy                  high whenever the sequencer is not idle
//   mem_we/addr/din       memory write enable, address, write data
//   mem_dout              memory read data, valid MEM_RD_LAT cycles after addr
//
// state  | meaning
// IDLE   | waiting for a request; the ack cycle of the previous access is here
// ACCESS | address/data/we presented to memory for one cycle
// WAIT   | read latency countdown, capture mem_dout when the count hits zero
// DONE   | completion; ack raised on the edge leaving this state

module mem_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  grant,
  output logic                  busy,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [1:0] CNT_INIT = (MEM_RD_LAT > 0) ? 2'(MEM_RD_LAT - 1) : 2'd0;

  state_t                state_q,      state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  grant_q,      grant_d;
  logic                  busy_q,       busy_d;
  logic                  ack0_q,       ack0_d;
  logic                  ack1_q,       ack1_d;
  logic                  mem_we_q,     mem_we_d;
  logic                  we_lat_q,     we_lat_d;
  logic [1:0]            cnt_q,        cnt_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q,   mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_din_q,    mem_din_d;
  logic [DATA_WIDTH-1:0] rdata0_q,     rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q,     rdata1_d;
  logic                  pick;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    busy_d       = busy_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    mem_we_d     = 1'b0;
    we_lat_d     = we_lat_q;
    cnt_d        = cnt_q;
    mem_addr_d   = mem_addr_q;
    mem_din_d    = mem_din_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    // Under contention the port that did not win last time goes first.
    pick         = (req0 && req1) ? ~last_grant_q : req1;

    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          grant_d    = pick;
          we_lat_d   = pick ? we1 : we0;
          mem_we_d   = pick ? we1 : we0;
          mem_addr_d = pick ? addr1 : addr0;
          mem_din_d  = pick ? wdata1 : wdata0;
          busy_d     = 1'b1;
          state_d    = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (we_lat_q) begin
          state_d = S_DONE;
        end else if (MEM_RD_LAT == 0) begin
          // Combinational memory: data is valid during ACCESS itself.
          if (grant_q) rdata1_d = mem_dout;
          else         rdata0_d = mem_dout;
          state_d = S_DONE;
        end else begin
          cnt_d   = CNT_INIT;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 2'd0) begin
          if (grant_q) rdata1_d = mem_dout;
          else         rdata0_d = mem_dout;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_DONE: begin
        ack0_d       = ~grant_q;
        ack1_d       = grant_q;
        last_grant_d = grant_q;
        busy_d       = 1'b0;
        state_d      = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      busy_q       <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      mem_we_q     <= 1'b0;
      we_lat_q     <= 1'b0;
      cnt_q        <= 2'd0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      busy_q       <= busy_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      mem_we_q     <= mem_we_d;
      we_lat_q     <= we_lat_d;
      cnt_q        <= cnt_d;
      mem_addr_q   <= mem_addr_d;
      mem_din_q    <= mem_din_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  // The memory writes on the edge ending ACCESS; masking with rst keeps a
  // reset asserted during ACCESS from committing the pending write.
  assign mem_we   = mem_we_q & ~rst;
  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;
  assign grant    = grant_q;
  assign busy     = busy_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter. Three instances share one clock:
//   k=0 MEM_RD_LAT=1, k=1 MEM_RD_LAT=0 (combinational read), k=2 MEM_RD_LAT=3.
// Each instance has its own memory model and its own reference model
// (memory contents, per-port read results, round-robin history).

module tb_mem_arbiter;

  logic clk;
  logic       rst    [3];
  logic       req0   [3];
  logic       req1   [3];
  logic       we0    [3];
  logic       we1    [3];
  logic [7:0] addr0  [3];
  logic [7:0] addr1  [3];
  logic [7:0] wdata0 [3];
  logic [7:0] wdata1 [3];
  logic       ack0   [3];
  logic       ack1   [3];
  logic [7:0] rdata0 [3];
  logic [7:0] rdata1 [3];
  logic       grant  [3];
  logic       busy   [3];
  logic       mem_we [3];
  logic [7:0] mem_addr [3];
  logic [7:0] mem_din  [3];
  logic [7:0] mem_dout [3];

  logic [7:0] mem  [3][256];
  logic [7:0] pipe [3][3];

  logic [7:0] ref_mem  [3][256];
  bit         ref_vld  [3][256];
  logic [7:0] m_rd0    [3];
  logic [7:0] m_rd1    [3];
  int         m_last   [3];

  int vectors = 0;
  int miscompares = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  mem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_RD_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst[0]), .req0(req0[0]), .req1(req1[0]), .we0(we0[0]), .we1(we1[0]),
    .addr0(addr0[0]), .addr1(addr1[0]), .wdata0(wdata0[0]), .wdata1(wdata1[0]),
    .ack0(ack0[0]), .ack1(ack1[0]), .rdata0(rdata0[0]), .rdata1(rdata1[0]),
    .grant(grant[0]), .busy(busy[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_din(mem_din[0]), .mem_dout(mem_dout[0]));

  mem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_RD_LAT(0)) u_lat0 (
    .clk(clk), .rst(rst[1]), .req0(req0[1]), .req1(req1[1]), .we0(we0[1]), .we1(we1[1]),
    .addr0(addr0[1]), .addr1(addr1[1]), .wdata0(wdata0[1]), .wdata1(wdata1[1]),
    .ack0(ack0[1]), .ack1(ack1[1]), .rdata0(rdata0[1]), .rdata1(rdata1[1]),
    .grant(grant[1]), .busy(busy[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_din(mem_din[1]), .mem_dout(mem_dout[1]));

  mem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_RD_LAT(3)) u_lat3 (
    .clk(clk), .rst(rst[2]), .req0(req0[2]), .req1(req1[2]), .we0(we0[2]), .we1(we1[2]),
    .addr0(addr0[2]), .addr1(addr1[2]), .wdata0(wdata0[2]), .wdata1(wdata1[2]),
    .ack0(ack0[2]), .ack1(ack1[2]), .rdata0(rdata0[2]), .rdata1(rdata1[2]),
    .grant(grant[2]), .busy(busy[2]), .mem_we(mem_we[2]), .mem_addr(mem_addr[2]),
    .mem_din(mem_din[2]), .mem_dout(mem_dout[2]));

  // Single-port memories: synchronous write, read data delayed by a
  // register pipeline of the instance's latency (none for k=1).
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (mem_we[k]) mem[k][mem_addr[k]] <= mem_din[k];
      pipe[k][0] <= mem[k][mem_addr[k]];
      pipe[k][1] <= pipe[k][0];
      pipe[k][2] <= pipe[k][1];
    end
  end

  assign mem_dout[0] = pipe[0][0];
  assign mem_dout[1] = mem[1][mem_addr[1]];
  assign mem_dout[2] = pipe[2][2];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
  endfunction

  task automatic model_reset(input int k);
    m_last[k] = 1;
    m_rd0[k]  = 8'h00;
    m_rd1[k]  = 8'h00;
  endtask

  // Run every requested transaction of one round to completion. Requests
  // are raised together; each port drops its req in its own ack cycle.
  task automatic run_round(input int k, input bit r0, input bit r1, input string tag);
    bit pend0, pend1, w_we;
    int win, n, lat, pulses;
    logic [7:0] w_addr, w_data, exp_rd;
    pend0 = r0;
    pend1 = r1;
    req0[k] = r0;
    req1[k] = r1;
    while (pend0 || pend1) begin
      if (pend0 && pend1) win = (m_last[k] == 0) ? 1 : 0;
      else                win = pend0 ? 0 : 1;
      w_we   = (win == 1) ? we1[k]    : we0[k];
      w_addr = (win == 1) ? addr1[k]  : addr0[k];
      w_data = (win == 1) ? wdata1[k] : wdata0[k];
      lat    = w_we ? 2 : 2 + lat_of(k);
      pulses = 0;
      n      = 0;
      @(posedge clk);
      forever begin
        @(negedge clk);
        if (mem_we[k]) begin
          pulses++;
          vectors++;
          if (mem_addr[k] !== w_addr || mem_din[k] !== w_data || n != 0) begin
            miscompares++;
            $display("FAIL %s mem_write k=%0d: got addr %h din %h at cycle %0d, expected addr %h din %h at cycle 0",
                     tag, k, mem_addr[k], mem_din[k], n, w_addr, w_data);
          end
        end
        if (n == 0) begin
          vectors++;
          if (busy[k] !== 1'b1 || grant[k] !== win[0]) begin
            miscompares++;
            $display("FAIL %s grant k=%0d: got busy %b grant %b, expected busy 1 grant %0d",
                     tag, k, busy[k], grant[k], win);
          end
        end
        if (ack0[k] === 1'b1 || ack1[k] === 1'b1) break;
        if (n >= 12) begin
          vectors++;
          miscompares++;
          $display("FAIL %s timeout k=%0d: got no ack after %0d cycles, expected ack at %0d", tag, k, n, lat);
          break;
        end
        @(posedge clk);
        n++;
      end
      vectors++;
      if (n != lat) begin
        miscompares++;
        $display("FAIL %s latency k=%0d port %0d: got %0d cycles, expected %0d", tag, k, win, n, lat);
      end
      vectors++;
      if (ack0[k] !== (win == 0) || ack1[k] !== (win == 1) || busy[k] !== 1'b0) begin
        miscompares++;
        $display("FAIL %s ack k=%0d: got ack0 %b ack1 %b busy %b, expected port %0d acked, busy 0",
                 tag, k, ack0[k], ack1[k], busy[k], win);
      end
      vectors++;
      if (pulses != (w_we ? 1 : 0)) begin
        miscompares++;
        $display("FAIL %s we_pulses k=%0d: got %0d, expected %0d", tag, k, pulses, w_we ? 1 : 0);
      end
      if (w_we) begin
        ref_mem[k][w_addr] = w_data;
        ref_vld[k][w_addr] = 1'b1;
      end else begin
        exp_rd = ref_mem[k][w_addr];
        if (win == 1) m_rd1[k] = exp_rd;
        else          m_rd0[k] = exp_rd;
      end
      vectors++;
      if (rdata0[k] !== m_rd0[k] || rdata1[k] !== m_rd1[k]) begin
        miscompares++;
        $display("FAIL %s rdata k=%0d: got rdata0 %h rdata1 %h, expected %h %h",
                 tag, k, rdata0[k], rdata1[k], m_rd0[k], m_rd1[k]);
      end
      m_last[k] = win;
      if (win == 1) begin req1[k] = 1'b0; pend1 = 1'b0; end
      else          begin req0[k] = 1'b0; pend0 = 1'b0; end
    end
  endtask

  task automatic test_reset(input int k);
    int we_seen;
    @(negedge clk);
    rst[k] = 1'b1; req0[k] = 1'b0; req1[k] = 1'b0;
    repeat (2) @(negedge clk);
    rst[k] = 1'b0;
    model_reset(k);
    vectors++;
    if ({ack0[k], ack1[k], busy[k], grant[k], mem_we[k]} !== 5'b0 ||
        mem_addr[k] !== 8'h00 || mem_din[k] !== 8'h00 ||
        rdata0[k] !== 8'h00 || rdata1[k] !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_state k=%0d: got ack %b%b busy %b grant %b we %b addr %h din %h rd %h %h, expected all 0",
               k, ack0[k], ack1[k], busy[k], grant[k], mem_we[k], mem_addr[k], mem_din[k], rdata0[k], rdata1[k]);
    end
    we_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_we[k] || busy[k] || ack0[k] || ack1[k]) we_seen++;
    end
    vectors++;
    if (we_seen != 0) begin
      miscompares++;
      $display("FAIL reset_idle k=%0d: got %0d active cycles, expected 0", k, we_seen);
    end
  endtask

  task automatic test_write_read();
    we0[0] = 1'b1; addr0[0] = 8'h00; wdata0[0] = 8'hA5;
    run_round(0, 1'b1, 1'b0, "p0_write");
    we1[0] = 1'b0; addr1[0] = 8'h00; wdata1[0] = 8'h3C;
    run_round(0, 1'b0, 1'b1, "p1_read");
  endtask

  task automatic test_contention();
    test_reset(0);
    we0[0] = 1'b1; addr0[0] = 8'h01; wdata0[0] = 8'h5A;
    we1[0] = 1'b1; addr1[0] = 8'h02; wdata1[0] = 8'hFF;
    run_round(0, 1'b1, 1'b1, "contend_wr");
    we0[0] = 1'b0; addr0[0] = 8'h01;
    we1[0] = 1'b0; addr1[0] = 8'h02;
    run_round(0, 1'b1, 1'b1, "contend_rd");
  endtask

  task automatic watch_quiet(input int k, input int cycles, input string tag);
    int bad;
    bad = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (ack0[k] || ack1[k] || mem_we[k]) bad++;
    end
    vectors++;
    if (bad != 0 || busy[k] !== 1'b0) begin
      miscompares++;
      $display("FAIL %s k=%0d: got %0d ack/we cycles busy %b, expected 0 and busy 0", tag, k, bad, busy[k]);
    end
  endtask

  task automatic test_reset_midway();
    // Port 0 read, reset while in WAIT.
    we0[0] = 1'b0; addr0[0] = 8'h01; req0[0] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst[0] = 1'b1; req0[0] = 1'b0;
    @(negedge clk);
    rst[0] = 1'b0;
    model_reset(0);
    watch_quiet(0, 6, "rst_in_wait");
    // Port 1 write, reset while in ACCESS.
    we1[0] = 1'b1; addr1[0] = 8'h02; wdata1[0] = 8'h77; req1[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst[0] = 1'b1; req1[0] = 1'b0;
    #1;
    vectors++;
    if (mem_we[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_in_access_we: got mem_we %b, expected 0", mem_we[0]);
    end
    @(negedge clk);
    rst[0] = 1'b0;
    model_reset(0);
    watch_quiet(0, 6, "rst_in_access");
    we0[0] = 1'b0; addr0[0] = 8'h02;
    run_round(0, 1'b1, 1'b0, "readback_02");
  endtask

  task automatic test_latency_variants();
    for (int k = 1; k < 3; k++) begin
      test_reset(k);
      we0[k] = 1'b1; addr0[k] = 8'h10; wdata0[k] = 8'hC3;
      run_round(k, 1'b1, 1'b0, "lat_write");
      we1[k] = 1'b0; addr1[k] = 8'h10;
      run_round(k, 1'b0, 1'b1, "lat_read");
    end
  endtask

  task automatic test_random(input int k, input int rounds);
    int r, a;
    for (int i = 0; i < rounds; i++) begin
      r = $urandom_range(1, 3);
      a = $urandom_range(0, 7);
      addr0[k] = 8'(a);
      we0[k] = !ref_vld[k][a] || ($urandom_range(0, 1) == 1);
      wdata0[k] = 8'($urandom);
      a = $urandom_range(0, 7);
      addr1[k] = 8'(a);
      we1[k] = !ref_vld[k][a] || ($urandom_range(0, 1) == 1);
      wdata1[k] = 8'($urandom);
      run_round(k, r[0], r[1], "random");
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; req0[k] = 1'b0; req1[k] = 1'b0; we0[k] = 1'b0; we1[k] = 1'b0;
      addr0[k] = 8'h00; addr1[k] = 8'h00; wdata0[k] = 8'h00; wdata1[k] = 8'h00;
      model_reset(k);
    end
    repeat (2) @(negedge clk);
    test_reset(0);
    test_write_read();
    test_contention();
    test_reset_midway();
    test_latency_variants();
    for (int k = 0; k < 3; k++) test_random(k, 40);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
